attn_qkv_rd_arbiter: RTL

ATTN_QKV_RD_ARBITER -- requirements
Module: attn_qkv_rd_arbiter

---
 rtl/attn_qkv_rd_if.sv | 24 ++
 rtl/attn_qkv_rd_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/attn_qkv_rd_if.sv
// Request/response bundle between the Q/K/V read requesters and the shared SRAM read port.
// The arbiter uses the slave modport; the requester/SRAM side uses master.
interface attn_qkv_rd_if;
    logic [2:0]   req_valid;
    logic [20:0]  req_addr;
    logic [2:0]   req_last;
    logic [2:0]   req_ready;
    logic         mem_en;
    logic [6:0]   mem_addr;
    logic [127:0] mem_rdata;
    logic [2:0]   rsp_valid;
    logic [127:0] rsp_data;
    logic         busy;

    modport master (
        output req_valid, req_addr, req_last, mem_rdata,
        input  req_ready, mem_en, mem_addr, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_addr, req_last, mem_rdata,
        output req_ready, mem_en, mem_addr, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/attn_qkv_rd_arbiter.sv
// Round-robin arbiter sharing one SRAM read port among score-Q, score-K and GEMM-V, with burst lock.
// Define ATTN_ARB_PERF_EN to add per-requester grant counters and a stall counter on perf_*.
//
// state    | meaning
// ARB_IDLE | round-robin grant from rr_ptr among valid requesters
// ARB_LOCK | burst in progress, ready held on owner until its last beat
module attn_qkv_rd_arbiter #(
    parameter int READ_LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    attn_qkv_rd_if.slave bus
`ifdef ATTN_ARB_PERF_EN
    ,
    input  logic [1:0]  perf_sel,
    input  logic        perf_clr,
    output logic [31:0] perf_cnt
`endif
);

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

    arb_state_e state_q, state_d;
    logic [1:0] rr_ptr_q, rr_ptr_d;
    logic [1:0] owner_q, owner_d;
    logic [6:0] mem_addr_q, mem_addr_d;

    logic [READ_LAT-1:0]       tag_vld_q, tag_vld_d;
    logic [READ_LAT-1:0][1:0]  tag_idx_q, tag_idx_d;

    logic [2:0] rr_cand;
    logic       rr_gnt_vld;
    logic [1:0] rr_gnt_idx;
    logic       gnt_vld;
    logic [1:0] gnt_idx;
    logic [2:0] gnt_ready;
    logic       hs;
    logic [6:0] sel_addr;
    logic       sel_last;

    // First valid requester at or after rr_ptr, wrapping 2 -> 0
    always_comb begin
        rr_cand    = 3'd0;
        rr_gnt_vld = 1'b0;
        rr_gnt_idx = 2'd0;
        for (int k = 0; k < 3; k++) begin
            rr_cand = {1'b0, rr_ptr_q} + 3'(k);
            if (rr_cand >= 3'd3) begin
                rr_cand = rr_cand - 3'd3;
            end
            if (!rr_gnt_vld && bus.req_valid[rr_cand[1:0]]) begin
                rr_gnt_vld = 1'b1;
                rr_gnt_idx = rr_cand[1:0];
            end
        end
    end

    always_comb begin
        gnt_vld = rr_gnt_vld;
        gnt_idx = rr_gnt_idx;
        if (state_q == ARB_LOCK) begin
            gnt_vld = 1'b1;
            gnt_idx = owner_q;
        end

        // No grant may escape while reset is held, even with requests pending
        gnt_ready = 3'b000;
        if (gnt_vld && rst_n) begin
            gnt_ready = 3'b001 << gnt_idx;
        end
        hs = |(bus.req_valid & gnt_ready);

        case (gnt_idx)
            2'd1:    begin sel_addr = bus.req_addr[13:7];  sel_last = bus.req_last[1]; end
            2'd2:    begin sel_addr = bus.req_addr[20:14]; sel_last = bus.req_last[2]; end
            default: begin sel_addr = bus.req_addr[6:0];   sel_last = bus.req_last[0]; end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        mem_addr_d = mem_addr_q;
        if (hs) begin
            mem_addr_d = sel_addr;
            if (sel_last) begin
                state_d  = ARB_IDLE;
                rr_ptr_d = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
            end else begin
                state_d = ARB_LOCK;
                owner_d = gnt_idx;
            end
        end
    end

    always_comb begin
        tag_vld_d    = '0;
        tag_idx_d    = '0;
        tag_vld_d[0] = hs;
        tag_idx_d[0] = gnt_idx;
        for (int s = 1; s < READ_LAT; s++) begin
            tag_vld_d[s] = tag_vld_q[s-1];
            tag_idx_d[s] = tag_idx_q[s-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            rr_ptr_q   <= 2'd0;
            owner_q    <= 2'd0;
            mem_addr_q <= 7'd0;
            tag_vld_q  <= '0;
            tag_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            mem_addr_q <= mem_addr_d;
            tag_vld_q  <= tag_vld_d;
            tag_idx_q  <= tag_idx_d;
        end
    end

    assign bus.req_ready = gnt_ready;
    assign bus.mem_en    = hs;
    assign bus.mem_addr  = mem_addr_d;
    assign bus.rsp_valid = tag_vld_q[READ_LAT-1] ? (3'b001 << tag_idx_q[READ_LAT-1]) : 3'b000;
    assign bus.rsp_data  = bus.mem_rdata;
    assign bus.busy      = (state_q == ARB_LOCK) || (|tag_vld_q);

`ifdef ATTN_ARB_PERF_EN
    logic [2:0][31:0] gnt_cnt_q, gnt_cnt_d;
    logic [31:0]      stall_cnt_q, stall_cnt_d;
    logic [2:0]       stall_vec;
    logic [1:0]       stall_inc;
    logic [32:0]      stall_sum;

    // Stall counter accumulates one per waiting requester per cycle
    always_comb begin
        stall_vec   = bus.req_valid & ~gnt_ready;
        stall_inc   = 2'(stall_vec[0]) + 2'(stall_vec[1]) + 2'(stall_vec[2]);
        stall_sum   = {1'b0, stall_cnt_q} + 33'(stall_inc);
        stall_cnt_d = stall_sum[32] ? 32'hFFFF_FFFF : stall_sum[31:0];
        for (int i = 0; i < 3; i++) begin
            gnt_cnt_d[i] = gnt_cnt_q[i];
            if (hs && (gnt_idx == 2'(i)) && (gnt_cnt_q[i] != 32'hFFFF_FFFF)) begin
                gnt_cnt_d[i] = gnt_cnt_q[i] + 32'd1;
            end
        end
        if (perf_clr) begin
            gnt_cnt_d   = '0;
            stall_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            gnt_cnt_q   <= gnt_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        case (perf_sel)
            2'd0:    perf_cnt = gnt_cnt_q[0];
            2'd1:    perf_cnt = gnt_cnt_q[1];
            2'd2:    perf_cnt = gnt_cnt_q[2];
            default: perf_cnt = stall_cnt_q;
        endcase
    end
`endif

endmodule
